// File: rtl/kd_internal_node_tree.sv
// rtl/kd_internal_node_tree.sv - KD-tree internal node store with pipelined root-to-leaf walk
// Nodes load breadth-first from a word stream; one query patch enters the walk per cycle.
module kd_internal_node_tree #(
   parameter int INTERNAL_WIDTH = 22,
   parameter int PATCH_WIDTH    = 55,
   parameter int ADDRESS_WIDTH  = 8,
   parameter int LEVELS         = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fsm_enable,
   input  logic                      sender_enable,
   input  logic [INTERNAL_WIDTH-1:0] sender_data,
   input  logic [PATCH_WIDTH-1:0]    patch_in,
   output logic [ADDRESS_WIDTH-1:0]  leaf_index
);

   localparam int NUM_DIMS  = PATCH_WIDTH / 11;
   localparam int NUM_NODES = (1 << LEVELS) - 1;
   localparam logic [LEVELS-1:0] FULL_CNT = LEVELS'(NUM_NODES);

   logic [10:0]        node_dim [NUM_NODES];
   logic signed [10:0] node_med [NUM_NODES];
   logic [LEVELS-1:0]  wr_cnt;
   logic               wr_en;

   logic [PATCH_WIDTH-1:0] st_patch [LEVELS];
   logic [LEVELS-1:0]      st_off   [LEVELS];
   logic [LEVELS-1:0]      next_off [LEVELS];

   // Out-of-range dimension selectors fall back to component 0.
   function automatic logic signed [10:0] sel_comp(input logic [PATCH_WIDTH-1:0] p,
                                                   input logic [10:0] dim);
      sel_comp = p[10:0];
      for (int d = 1; d < NUM_DIMS; d++) begin
         if (dim == 11'(d)) sel_comp = p[11*d +: 11];
      end
   endfunction

   assign wr_en = fsm_enable && sender_enable && (wr_cnt != FULL_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt <= '0;
         for (int n = 0; n < NUM_NODES; n++) begin
            node_dim[n] <= '0;
            node_med[n] <= '0;
         end
      end else if (wr_en) begin
         node_dim[wr_cnt] <= sender_data[10:0];
         node_med[wr_cnt] <= sender_data[21:11];
         wr_cnt           <= wr_cnt + 1'b1;
      end
   end

   // Level l starts at global node 2^l-1; each stage reads only its own level.
   always_comb begin
      for (int l = 0; l < LEVELS; l++) begin
         next_off[l] = {st_off[l][LEVELS-2:0],
                        (sel_comp(st_patch[l], node_dim[LEVELS'((1 << l) - 1) + st_off[l]])
                         > node_med[LEVELS'((1 << l) - 1) + st_off[l]])};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < LEVELS; l++) begin
            st_patch[l] <= '0;
            st_off[l]   <= '0;
         end
         leaf_index <= '0;
      end else begin
         st_patch[0] <= patch_in;
         st_off[0]   <= '0;
         for (int l = 1; l < LEVELS; l++) begin
            st_patch[l] <= st_patch[l-1];
            st_off[l]   <= next_off[l-1];
         end
         leaf_index <= ADDRESS_WIDTH'(next_off[LEVELS-1]);
      end
   end

endmodule

// File: tb/tb_kd_internal_node_tree.sv
// tb/tb_kd_internal_node_tree.sv - directed self-checking bench for kd_internal_node_tree
module tb_kd_internal_node_tree;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fsm_enable;
   logic        sender_enable;
   logic [21:0] sender_data;
   logic [54:0] patch_in;
   logic [7:0]  leaf_index;

   int n_cmp  = 0;
   int n_fail = 0;

   int                 m_dim [63];
   logic signed [10:0] m_med [63];

   kd_internal_node_tree dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fsm_enable    (fsm_enable),
      .sender_enable (sender_enable),
      .sender_data   (sender_data),
      .patch_in      (patch_in),
      .leaf_index    (leaf_index)
   );

   always #5 clk = ~clk;

   function automatic logic [54:0] mk_patch(int c0, int c1, int c2, int c3, int c4);
      logic [10:0] a0, a1, a2, a3, a4;
      a0 = 11'(c0); a1 = 11'(c1); a2 = 11'(c2); a3 = 11'(c3); a4 = 11'(c4);
      return {a4, a3, a2, a1, a0};
   endfunction

   function automatic int model_leaf(logic [54:0] p);
      int off, idx, d;
      logic signed [10:0] c;
      off = 0;
      for (int l = 0; l < 6; l++) begin
         idx = (1 << l) - 1 + off;
         d = (m_dim[idx] >= 5) ? 0 : m_dim[idx];
         c = p[11*d +: 11];
         off = off * 2 + ((c > m_med[idx]) ? 1 : 0);
      end
      return off;
   endfunction

   function automatic logic [54:0] rand_patch();
      return mk_patch($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                      $urandom_range(0, 2047), $urandom_range(0, 2047));
   endfunction

   task automatic clear_model();
      for (int n = 0; n < 63; n++) begin
         m_dim[n] = 0;
         m_med[n] = '0;
      end
   endtask

   task automatic write_word(input int dim, input logic signed [10:0] med);
      @(negedge clk);
      sender_data   = {med, 11'(dim)};
      sender_enable = 1'b1;
      @(negedge clk);
      sender_enable = 1'b0;
   endtask

   task automatic load_model(input int count, input bit stalls);
      fsm_enable = 1'b1;
      for (int n = 0; n < count; n++) begin
         if (stalls) repeat ($urandom_range(0, 2)) @(negedge clk);
         write_word(m_dim[n], m_med[n]);
      end
      fsm_enable = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic query(input logic [54:0] p, input int exp, input string name);
      @(negedge clk);
      patch_in = p;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (leaf_index !== 8'(exp)) begin
         n_fail++;
         $display("FAIL %s: leaf_index=%0d expected=%0d", name, leaf_index, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fsm_enable = 1'b0; sender_enable = 1'b0;
      sender_data = '0; patch_in = '0;
      #1;
      n_cmp++;
      if (leaf_index !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_leaf: leaf_index=%0d expected=0", leaf_index);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      query(mk_patch(0, 0, 0, 0, 0), 0, "reset_zero_tree_tie");
   endtask

   task automatic test_gating_and_uniform();
      do_reset();
      clear_model();
      fsm_enable = 1'b0;
      repeat (3) write_word(0, -11'sd100);
      load_model(63, 1'b0);
      query(mk_patch(-5, 0, 0, 0, 0), 0, "uniform_neg");
      query(mk_patch(5, 0, 0, 0, 0), 63, "uniform_pos");
      query(mk_patch(0, 0, 0, 0, 0), 0, "uniform_tie_left");
      fsm_enable = 1'b1;
      write_word(0, -11'sd100);
      fsm_enable = 1'b0;
      query(mk_patch(-5, 0, 0, 0, 0), 0, "write_after_full_ignored");
   endtask

   task automatic test_dim_clamp();
      do_reset();
      clear_model();
      m_dim[0] = 7;
      load_model(63, 1'b0);
      query(mk_patch(1, -50, -50, -50, -50), 63, "clamp_pos");
      query(mk_patch(-1, 100, 100, 100, 100), 0, "clamp_neg");
   endtask

   task automatic load_random_tree();
      for (int n = 0; n < 63; n++) begin
         m_dim[n] = $urandom_range(0, 6);
         m_med[n] = 11'($urandom_range(0, 2047));
      end
   endtask

   task automatic test_full_load();
      logic [54:0] p;
      do_reset();
      load_random_tree();
      load_model(63, 1'b1);
      p = mk_patch(79, -88, -1, -26, 251);
      query(p, model_leaf(p), "real_patch");
      for (int i = 0; i < 20; i++) begin
         p = rand_patch();
         query(p, model_leaf(p), "random_patch");
      end
   endtask

   task automatic test_back_to_back();
      logic [54:0] pq [12];
      int          ex [12];
      for (int i = 0; i < 12; i++) begin
         pq[i] = rand_patch();
         ex[i] = model_leaf(pq[i]);
      end
      for (int j = 0; j < 12 + 7; j++) begin
         @(negedge clk);
         if (j >= 7) begin
            n_cmp++;
            if (leaf_index !== 8'(ex[j-7])) begin
               n_fail++;
               $display("FAIL pipeline[%0d]: leaf_index=%0d expected=%0d", j - 7, leaf_index, ex[j-7]);
            end
         end
         if (j < 12) patch_in = pq[j];
      end
   endtask

   task automatic test_reset_midload();
      logic [54:0] p;
      do_reset();
      clear_model();
      for (int n = 0; n < 30; n++) begin
         m_dim[n] = $urandom_range(0, 4);
         m_med[n] = -11'sd1000;
      end
      load_model(30, 1'b1);
      query(mk_patch(500, 500, 500, 500, 500), 63, "partial_load_right");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (leaf_index !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset_clear: leaf_index=%0d expected=0", leaf_index);
      end
      @(negedge clk);
      rst_n = 1'b1;
      load_random_tree();
      load_model(63, 1'b1);
      for (int i = 0; i < 10; i++) begin
         p = rand_patch();
         query(p, model_leaf(p), "reload_after_reset");
      end
   endtask

   initial begin
      test_reset();
      test_gating_and_uniform();
      test_dim_clamp();
      test_full_load();
      test_back_to_back();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/kd_internal_node_tree.md
Name: kd_internal_node_tree

Overview:
- Stores the internal nodes of a complete binary KD-tree and routes one query patch per cycle from root to leaf.
- Outputs the patch's leaf index.
- Nodes arrive as a stream of 22-bit words from the aggregator, which packs two 11-bit words read from the async FIFO.
- Sits between the node-load path and the leaf/candidate search stage of the ANN accelerator.

Parameters:
- INTERNAL_WIDTH, 22: node word width; [10:0] = split dimension, [21:11] = signed median.
- PATCH_WIDTH, 55: query patch width; NUM_DIMS = PATCH_WIDTH/11 = 5 signed 11-bit components.
- ADDRESS_WIDTH, 8: width of leaf_index.
- LEVELS, 6: tree depth; 2^LEVELS-1 = 63 internal nodes and 2^LEVELS = 64 leaves.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- fsm_enable  input  1  load window; node writes accepted only while high
- sender_enable  input  1  one node word valid this cycle
- sender_data  input  INTERNAL_WIDTH  node word: [10:0] dimension, [21:11] median (two's complement)
- patch_in  input  PATCH_WIDTH  query patch; component d = bits [11d+10:11d], signed, d=0 at LSB
- leaf_index  output  ADDRESS_WIDTH  leaf reached by the patch, zero-extended

Behaviour:
- Reset is asynchronous, active-low. It clears all node storage (dim=0, median=0), the write counter, every pipeline stage, and leaf_index, all to 0.
- Node storage is organized per level: level l holds 2^l nodes, giving 63 entries for LEVELS=6. Each level is read independently so the walk can be pipelined.
- Loading:
  - A write occurs on a rising clk edge where fsm_enable && sender_enable.
  - sender_data goes to node number wr_cnt, in breadth-first order (root=0; children of n are 2n+1 and 2n+2). wr_cnt then increments.
  - After 63 writes, wr_cnt saturates and further writes are ignored until reset.
  - When fsm_enable is low, sender_enable is ignored, both for storage and for the counter.
- Traversal is a LEVELS-stage pipeline, one level per stage.
  - Stage 0 registers patch_in and compares at the root.
  - Stage l holds the registered patch and a node offset within level l.
  - At each node: comp = patch component [dim]. If dim >= NUM_DIMS, component 0 is used.
  - Signed compare: comp <= median goes left (offset*2); comp > median goes right (offset*2+1).
  - After the last level, leaf_index <= final offset (0..63), registered.
- Latency: leaf_index reflects the patch_in sampled LEVELS+1 clk edges earlier (7 edges for defaults).
- Throughput: one patch per cycle. The output holds steady while patch_in is held.
- Traversal runs regardless of fsm_enable.
- A write to a node in the same cycle that the node is read: the read returns the old value.
- Reset mid-load discards all loaded nodes; the next load restarts at node 0.
- Median and patch components are compared as 11-bit two's complement; no widening is needed.
- Unused upper bits of the dimension field ([10:3]) are ignored except through the dim >= NUM_DIMS rule above.

Test Plan:
- Full load and real query:
  - Stimulus: stream 63 node words from the FIFO/aggregator with fsm_enable=1 and random FIFO stalls, then drop fsm_enable. Apply patch components d0..d4 = 79, -88, -1, -26, 251.
  - Required: leaf_index = 63 with the delivered node set; the bench compares against a software KD model for 20 random patches.
- Uniform tree, boundary values:
  - Stimulus: load all nodes as dim=0, median=0.
  - Required: patch d0=-5 gives leaf 0; d0=+5 gives leaf 63; d0=0 (equal to median) gives leaf 0 (ties go left).
- Load gating:
  - Stimulus: with fsm_enable=0, pulse sender_enable with dim=0, median=-100; then query d0=-5.
  - Required: leaf 0, since storage is unchanged.
  - Also: a 64th write after 63 accepted is ignored.
- Latency and pipelining:
  - Stimulus: apply distinct patches on consecutive cycles.
  - Required: each result appears exactly LEVELS+1 edges later, in order, with no bubbles.
- Reset:
  - Stimulus: assert rst_n low mid-load (after 30 nodes).
  - Required: leaf_index = 0 immediately. After release, reload 63 nodes starting from node 0 and the results match the model.
- Dimension clamp:
  - Stimulus: root dim=7, median=0, remaining nodes dim=0, median=0.
  - Required: d0 sign alone decides the root branch; d0=+1 gives leaf 63.
